// File: rtl/mips_muldiv_defs.sv
// Shared definitions for the iterative multiply/divide unit.
//   md_op_e            : op field encodings as issued by decode
//   md_state_e         : sequencer states (IDLE -> RUN -> FIX -> IDLE)
//   md_params_legal()  : elaboration-time check of DATA_W / BITS_PER_CYCLE
package mips_muldiv_defs;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Throughput may only be 1, 2 or 4 bits per clock and must split DATA_W
  // into whole iterations; DATA_W itself must be even and at least 8.
  function automatic bit md_params_legal(input int data_w, input int bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4)) &&
           (data_w >= 8) && ((data_w % 2) == 0) && ((data_w % bpc) == 0);
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
//   div_mode : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_in   : 2*DATA_W accumulator
//              multiply: running product, shifted right one bit per step
//              divide  : {remainder, quotient}
//   a_in     : multiply: multiplicand (constant)
//              divide  : dividend, consumed MSB first (shifted left)
//   b_in     : multiply: multiplier, consumed LSB first (shifted right)
//              divide  : divisor (constant)
//   acc_out, a_out, b_out : the same quantities after one step
module mips_muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic                  div_mode,
  input  logic [2*DATA_W-1:0]   acc_in,
  input  logic [DATA_W-1:0]     a_in,
  input  logic [DATA_W-1:0]     b_in,
  output logic [2*DATA_W-1:0]   acc_out,
  output logic [DATA_W-1:0]     a_out,
  output logic [DATA_W-1:0]     b_out
);

  logic [DATA_W:0]   sum;      // upper product half plus multiplicand, with carry
  logic [DATA_W:0]   r_shift;  // remainder shifted left with next dividend bit
  logic              ge;       // trial subtraction succeeds
  logic [DATA_W-1:0] rem_next;

  // NOTE: every variable is given a value on every path through this block,
  // so no storage (latch) is inferred for any of them.
  always_comb begin
    sum      = {1'b0, acc_in[2*DATA_W-1:DATA_W]} + (b_in[0] ? {1'b0, a_in} : '0);
    r_shift  = {acc_in[2*DATA_W-1:DATA_W], a_in[DATA_W-1]};
    ge       = (r_shift >= {1'b0, b_in});
    // When the subtraction succeeds the result is below the divisor, so the
    // low DATA_W bits of the difference are the whole new remainder.
    rem_next = ge ? (r_shift[DATA_W-1:0] - b_in) : r_shift[DATA_W-1:0];

    if (div_mode) begin
      acc_out = {rem_next, acc_in[DATA_W-2:0], ge};
      a_out   = {a_in[DATA_W-2:0], 1'b0};
      b_out   = b_in;
    end else begin
      acc_out = {sum, acc_in[DATA_W-1:1]};
      a_out   = a_in;
      b_out   = {1'b0, b_in[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with the architectural HI/LO registers.
// MTHI/MTLO complete at their accept edge; multiply/divide run N = DATA_W /
// BITS_PER_CYCLE iteration cycles on magnitudes, then one FIX cycle applies
// the two's-complement sign correction and writes HI/LO.
//   clk, rst     : clock, synchronous active-high reset
//   en           : global enable; low freezes every register (done reads 0)
//   start, op    : issue request and operation (md_op_e encoding)
//   op_a, op_b   : rs / rt operands
//   kill         : abandons an in-flight MULT/DIV, HI/LO untouched
//   busy         : MULT/DIV in flight (state != IDLE)
//   done         : HI/LO were written by a MULT/DIV at the previous edge
//   hi, lo       : HI and LO registers
module mips_muldiv_unit
  import mips_muldiv_defs::*;
#(
  parameter int DATA_W         = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              kill,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int N     = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int W2    = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (!md_params_legal(DATA_W, BITS_PER_CYCLE)) begin : g_bad_params
    $error("mips_muldiv_unit: illegal DATA_W / BITS_PER_CYCLE combination");
  end

  md_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [W2-1:0]     acc;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic              is_div;
  logic              neg_lo;   // sign of product / quotient
  logic              neg_hi;   // sign of remainder (follows the dividend)
  logic              done_q;

  // Operand magnitudes. A most-negative operand negates to itself, which as
  // an unsigned DATA_W value is exactly its magnitude 2**(DATA_W-1).
  md_op_e            op_e;
  logic              signed_op;
  logic              sign_a;
  logic              sign_b;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;

  assign op_e      = md_op_e'(op);
  assign signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign sign_a    = signed_op & op_a[DATA_W-1];
  assign sign_b    = signed_op & op_b[DATA_W-1];
  assign mag_a     = sign_a ? -op_a : op_a;
  assign mag_b     = sign_b ? -op_b : op_b;

  // BITS_PER_CYCLE steps chained combinationally per RUN cycle.
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    logic [W2-1:0]     acc_i;
    logic [W2-1:0]     acc_o;
    logic [DATA_W-1:0] a_i;
    logic [DATA_W-1:0] a_o;
    logic [DATA_W-1:0] b_i;
    logic [DATA_W-1:0] b_o;

    if (i == 0) begin : g_first
      assign acc_i = acc;
      assign a_i   = a_reg;
      assign b_i   = b_reg;
    end else begin : g_next
      assign acc_i = g_step[i-1].acc_o;
      assign a_i   = g_step[i-1].a_o;
      assign b_i   = g_step[i-1].b_o;
    end

    mips_muldiv_step #(.DATA_W(DATA_W)) u_step (
      .div_mode (is_div),
      .acc_in   (acc_i),
      .a_in     (a_i),
      .b_in     (b_i),
      .acc_out  (acc_o),
      .a_out    (a_o),
      .b_out    (b_o)
    );
  end

  // Sign correction applied in FIX. The divisor register is never shifted
  // during a divide, so it still tells us whether this was a divide by zero;
  // the remainder path then already reproduces the original dividend.
  logic [W2-1:0]     prod_fix;
  logic [DATA_W-1:0] quo_mag;
  logic [DATA_W-1:0] rem_mag;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;

  assign quo_mag  = acc[DATA_W-1:0];
  assign rem_mag  = acc[W2-1:DATA_W];
  assign prod_fix = neg_lo ? -acc : acc;
  assign quo_fix  = (b_reg == '0) ? '1 : (neg_lo ? -quo_mag : quo_mag);
  assign rem_fix  = neg_hi ? -rem_mag : rem_mag;

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: acc, a_reg, b_reg and the sign/mode latches carry no reset; they
  // are always loaded at the accept edge before anything reads them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done_q <= 1'b0;
    end else if (kill && (state != MD_IDLE)) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (en) begin
      done_q <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start && !kill) begin
            case (op_e)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                state  <= MD_RUN;
                cnt    <= '0;
                acc    <= '0;
                a_reg  <= mag_a;
                b_reg  <= mag_b;
                is_div <= (op_e == MD_DIV) || (op_e == MD_DIVU);
                neg_lo <= sign_a ^ sign_b;
                neg_hi <= sign_a;
              end
              MD_MTHI: hi <= op_a;
              MD_MTLO: lo <= op_a;
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          acc   <= g_step[BITS_PER_CYCLE-1].acc_o;
          a_reg <= g_step[BITS_PER_CYCLE-1].a_o;
          b_reg <= g_step[BITS_PER_CYCLE-1].b_o;
          if (cnt == CNT_LAST) begin
            state <= MD_FIX;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MD_FIX: begin
          state  <= MD_IDLE;
          done_q <= 1'b1;
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy = (state != MD_IDLE);
  // A pending done is held in done_q while frozen and shows once en returns.
  assign done = done_q & en;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit. Two instances (1 and 4 bits per
// cycle) are each shadowed by a transaction-level model that computes HI/LO
// with plain 64-bit arithmetic and tracks busy/done as a cycle countdown.
module tb_mips_muldiv_unit;

  localparam int W = 32;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_s   [2];
  logic         en_s    [2];
  logic         start_s [2];
  logic         kill_s  [2];
  logic [2:0]   op_s    [2];
  logic [W-1:0] a_s     [2];
  logic [W-1:0] b_s     [2];
  logic         busy_s  [2];
  logic         done_s  [2];
  logic [W-1:0] hi_s    [2];
  logic [W-1:0] lo_s    [2];

  mips_muldiv_unit #(.DATA_W(W), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst_s[0]), .en(en_s[0]), .start(start_s[0]), .op(op_s[0]),
    .op_a(a_s[0]), .op_b(b_s[0]), .kill(kill_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .hi(hi_s[0]), .lo(lo_s[0])
  );

  mips_muldiv_unit #(.DATA_W(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst_s[1]), .en(en_s[1]), .start(start_s[1]), .op(op_s[1]),
    .op_a(a_s[1]), .op_b(b_s[1]), .kill(kill_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .hi(hi_s[1]), .lo(lo_s[1])
  );

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi, lo} straight from the instruction semantics.
  function automatic logic [63:0] ref_hilo(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    case (op)
      OP_MULT:  res = sa * sb;
      OP_MULTU: res = ua * ub;
      OP_DIV, OP_DIVU: begin
        if (b == '0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (op == OP_DIV) begin
          q = sa / sb;  // truncates toward zero; MIN/-1 wraps to MIN in 32 bits
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic int busy_len(input int d);
    return (d == 0) ? (W / 1 + 1) : (W / 4 + 1);
  endfunction

  // Transaction-level model state
  logic         m_busy [2];
  logic         m_done [2];
  logic [W-1:0] m_hi   [2];
  logic [W-1:0] m_lo   [2];
  logic [63:0]  m_res  [2];
  int           m_left [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_s[d]) begin
        m_busy[d] <= 1'b0;
        m_done[d] <= 1'b0;
        m_hi[d]   <= '0;
        m_lo[d]   <= '0;
        m_left[d] <= 0;
      end else if (kill_s[d] && m_busy[d]) begin
        m_busy[d] <= 1'b0;
        m_left[d] <= 0;
      end else if (en_s[d]) begin
        m_done[d] <= 1'b0;
        if (m_busy[d]) begin
          if (m_left[d] == 1) begin
            m_busy[d] <= 1'b0;
            m_done[d] <= 1'b1;
            m_hi[d]   <= m_res[d][63:32];
            m_lo[d]   <= m_res[d][31:0];
          end
          m_left[d] <= m_left[d] - 1;
        end else if (start_s[d] && !kill_s[d]) begin
          case (op_s[d])
            OP_MTHI: m_hi[d] <= a_s[d];
            OP_MTLO: m_lo[d] <= a_s[d];
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              m_res[d]  <= ref_hilo(op_s[d], a_s[d], b_s[d]);
              m_busy[d] <= 1'b1;
              m_left[d] <= busy_len(d);
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d_busy", d), 64'(busy_s[d]), 64'(m_busy[d]));
        check($sformatf("d%0d_done", d), 64'(done_s[d]), 64'(m_done[d] & en_s[d]));
        check($sformatf("d%0d_hi", d), 64'(hi_s[d]), 64'(m_hi[d]));
        check($sformatf("d%0d_lo", d), 64'(lo_s[d]), 64'(m_lo[d]));
        if (start_s[d] && en_s[d] && m_busy[d] && !kill_s[d] && !rst_s[d]) begin
          errors++;
          $display("FAIL d%0d_protocol: start issued while busy (t=%0t)", d, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on an idle instance; report busy cycles and done pulses.
  task automatic run_op(input int d, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int bc, output int dn);
    bc = 0;
    dn = 0;
    tick();
    start_s[d] = 1'b1; op_s[d] = op; a_s[d] = a; b_s[d] = b;
    tick();
    start_s[d] = 1'b0;
    @(negedge clk);
    while (busy_s[d] && bc < 200) begin
      bc++;
      if (done_s[d]) dn++;
      @(negedge clk);
    end
    if (done_s[d]) dn++;
    @(negedge clk);
    if (done_s[d]) dn++;
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_run(input int d, input int nops);
    int ops   = 0;
    int guard = 0;
    while (ops < nops && guard < 60000) begin
      tick();
      guard++;
      start_s[d] = 1'b0;
      kill_s[d]  = 1'b0;
      en_s[d]    = ($urandom_range(0, 9) != 0);
      rst_s[d]   = ($urandom_range(0, 2999) == 0);
      if (m_busy[d]) begin
        kill_s[d] = ($urandom_range(0, 99) == 0);
      end else if ($urandom_range(0, 3) != 0) begin
        start_s[d] = 1'b1;
        op_s[d]    = ($urandom_range(0, 4) != 0) ? 3'($urandom_range(0, 3))
                                                 : 3'($urandom_range(4, 7));
        a_s[d]     = rand_operand();
        b_s[d]     = rand_operand();
        kill_s[d]  = ($urandom_range(0, 19) == 0);
        ops++;
      end
    end
    tick();
    start_s[d] = 1'b0; kill_s[d] = 1'b0; en_s[d] = 1'b1; rst_s[d] = 1'b0;
    for (int i = 0; i < 100 && busy_s[d]; i++) tick();
    check($sformatf("d%0d_drain_busy", d), 64'(busy_s[d]), 64'd0);
  endtask

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs [6];
  int   bc, dn, n_cyc;
  logic done_seen;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; en_s[d] = 1'b1; start_s[d] = 1'b0; kill_s[d] = 1'b0;
      op_s[d] = '0; a_s[d] = '0; b_s[d] = '0;
    end
    repeat (3) tick();
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    cmp_on = 1'b1;

    @(negedge clk);
    check("reset_hi", 64'(hi_s[0]), 64'd0);
    check("reset_lo", 64'(lo_s[0]), 64'd0);
    check("reset_busy", 64'(busy_s[0]), 64'd0);
    check("reset_done", 64'(done_s[0]), 64'd0);

    // Hand-computed pins of the reference model itself
    check("ref_mult", ref_hilo(OP_MULT, 32'hFFFF_FFFF, 32'h2), 64'hFFFF_FFFF_FFFF_FFFE);
    check("ref_div_min", ref_hilo(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    check("ref_div0", ref_hilo(OP_DIV, 32'hFFFF_FFF9, 32'h0), 64'hFFFF_FFF9_FFFF_FFFF);

    // MULT with 1 bit/cycle: 33 busy cycles, single done
    run_op(0, OP_MULT, 32'hFFFF_FFFF, 32'h2, bc, dn);
    check("mult_busy_cycles", 64'(bc), 64'd33);
    check("mult_done_pulses", 64'(dn), 64'd1);
    check("mult_hi", 64'(hi_s[0]), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo_s[0]), 64'hFFFF_FFFE);

    vecs[0] = '{op: OP_MULTU, a: 32'hFFFF_FFFF, b: 32'h2,         hi: 32'h1,         lo: 32'hFFFF_FFFE};
    vecs[1] = '{op: OP_DIV,   a: 32'hFFFF_FFF9, b: 32'h2,         hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD};
    vecs[2] = '{op: OP_DIVU,  a: 32'h7,         b: 32'h0,         hi: 32'h7,         lo: 32'hFFFF_FFFF};
    vecs[3] = '{op: OP_DIV,   a: 32'h8000_0000, b: 32'hFFFF_FFFF, hi: 32'h0,         lo: 32'h8000_0000};
    vecs[4] = '{op: OP_DIVU,  a: 32'd100,       b: 32'd7,         hi: 32'd2,         lo: 32'd14};
    vecs[5] = '{op: OP_MULT,  a: 32'hFFFF_FFFD, b: 32'd5,         hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF1};
    for (int i = 0; i < 6; i++) begin
      run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, bc, dn);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd33);
      check($sformatf("vec%0d_done_pulses", i), 64'(dn), 64'd1);
      check($sformatf("vec%0d_hi", i), 64'(hi_s[0]), 64'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(lo_s[0]), 64'(vecs[i].lo));
    end

    // MTHI then MTLO back to back
    tick();
    start_s[0] = 1'b1; op_s[0] = OP_MTHI; a_s[0] = 32'h1234_5678;
    tick();
    op_s[0] = OP_MTLO; a_s[0] = 32'h9ABC_DEF0;
    @(negedge clk);
    check("mthi_hi", 64'(hi_s[0]), 64'h1234_5678);
    check("mthi_busy", 64'(busy_s[0]), 64'd0);
    check("mthi_done", 64'(done_s[0]), 64'd0);
    tick();
    start_s[0] = 1'b0;
    @(negedge clk);
    check("mtlo_lo", 64'(lo_s[0]), 64'h9ABC_DEF0);
    check("mtlo_hi_kept", 64'(hi_s[0]), 64'h1234_5678);
    check("mtlo_busy", 64'(busy_s[0]), 64'd0);
    check("mtlo_done", 64'(done_s[0]), 64'd0);

    // Preload 5/5, then kill in RUN cycle 10
    run_op(0, OP_MTHI, 32'h5, 32'h0, bc, dn);
    run_op(0, OP_MTLO, 32'h5, 32'h0, bc, dn);
    tick();
    start_s[0] = 1'b1; op_s[0] = OP_MULT; a_s[0] = 32'h0001_0000; b_s[0] = 32'h0001_0000;
    tick();
    start_s[0] = 1'b0;
    repeat (9) tick();
    kill_s[0] = 1'b1;
    tick();
    kill_s[0] = 1'b0;
    @(negedge clk);
    check("kill_busy", 64'(busy_s[0]), 64'd0);
    check("kill_hi", 64'(hi_s[0]), 64'h5);
    check("kill_lo", 64'(lo_s[0]), 64'h5);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_s[0]) dn++;
    end
    check("kill_no_done", 64'(dn), 64'd0);

    // Restart with en held low for 5 cycles mid-RUN
    tick();
    start_s[0] = 1'b1; op_s[0] = OP_MULT; a_s[0] = 32'h0001_0000; b_s[0] = 32'h0001_0000;
    tick();
    start_s[0] = 1'b0;
    fork
      begin
        repeat (10) tick();
        en_s[0] = 1'b0;
        repeat (5) tick();
        en_s[0] = 1'b1;
      end
      begin
        n_cyc = 0;
        done_seen = 1'b0;
        while (!done_seen && n_cyc < 200) begin
          @(negedge clk);
          n_cyc++;
          done_seen = done_s[0];
        end
      end
    join
    check("freeze_done_cycle", 64'(n_cyc), 64'd39);
    check("freeze_hi", 64'(hi_s[0]), 64'h1);
    check("freeze_lo", 64'(lo_s[0]), 64'h0);

    // Reset in the middle of RUN
    tick();
    start_s[0] = 1'b1; op_s[0] = OP_MULTU; a_s[0] = 32'h0000_0003; b_s[0] = 32'h0000_0007;
    tick();
    start_s[0] = 1'b0;
    repeat (10) tick();
    rst_s[0] = 1'b1;
    tick();
    rst_s[0] = 1'b0;
    @(negedge clk);
    check("rst_hi", 64'(hi_s[0]), 64'd0);
    check("rst_lo", 64'(lo_s[0]), 64'd0);
    check("rst_busy", 64'(busy_s[0]), 64'd0);
    check("rst_done", 64'(done_s[0]), 64'd0);

    // 4 bits per cycle
    run_op(1, OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF, bc, dn);
    check("bpc4_busy_cycles", 64'(bc), 64'd9);
    check("bpc4_done_pulses", 64'(dn), 64'd1);
    check("bpc4_hi", 64'(hi_s[1]), 64'h0);
    check("bpc4_lo", 64'(lo_s[1]), 64'hFFFE_0001);

    // Randomised sweep on both instances in parallel
    fork
      rand_run(0, 300);
      rand_run(1, 3000);
    join

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
